// File: rtl/board_io_pkg.sv
// board_io_pkg: shared reset-FSM encoding and counter sizing for board_io_ctrl
// Contents: state_t (ST_HOLD, ST_STRETCH, ST_RUN), cnt_w() bits needed to count 0..n-1.
package board_io_pkg;
  typedef enum logic [1:0] {ST_HOLD, ST_STRETCH, ST_RUN} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/board_io_debounce.sv
// board_io_debounce: one switch channel, 2-flop sync, stability counter, level and edge pulses
// Ports: clk, reset (sync, active-low), sw_in (raw pin), sw_db (debounced level),
//        sw_rise / sw_fall (1-cycle pulses on debounced 0->1 / 1->0).
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_db,
  output logic sw_rise,
  output logic sw_fall
);
  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
  logic sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d, rise_q, rise_d, fall_q, fall_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync1_d = sw_in;
    sync2_d = sync1_q;
    flip    = (sync2_q != db_q) && (cnt_q == DB_MAX);
    // any sample that agrees with the accepted level restarts the stability window
    cnt_d   = (sync2_q == db_q || flip) ? '0 : cnt_q + 1'b1;
    db_d    = flip ? ~db_q : db_q;
    rise_d  = flip & ~db_q;
    fall_d  = flip & db_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign sw_db   = db_q;
  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board I/O conditioning -- switch debounce, SoC reset sequencing, PWM LED drive
// Ports: clk, reset (sync, active-low), sw_in -> sw_db/sw_rise/sw_fall, soc_reset_n (active-low),
//        led_val + led_duty -> led_out (registered).
// Option: define BOARD_IO_HEARTBEAT_EN to turn led_out[LED_W-1] into a heartbeat (HB_CYCLES).
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int SW_W       = 4,
  parameter int LED_W      = 8,
  parameter int DB_CYCLES  = 500000,
  parameter int POR_CYCLES = 1024,
  parameter int RST_SW     = 0,
  parameter int PWM_BITS   = 8
`ifdef BOARD_IO_HEARTBEAT_EN
  , parameter int HB_CYCLES = 25000000
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_W-1:0]     sw_in,
  output logic [SW_W-1:0]     sw_db,
  output logic [SW_W-1:0]     sw_rise,
  output logic [SW_W-1:0]     sw_fall,
  output logic                soc_reset_n,
  input  logic [LED_W-1:0]    led_val,
  input  logic [PWM_BITS-1:0] led_duty,
  output logic [LED_W-1:0]    led_out
);
  localparam int RW = cnt_w(POR_CYCLES);
  localparam logic [RW-1:0] POR_MAX = RW'(POR_CYCLES - 1);
  for (genvar i = 0; i < SW_W; i++) begin : g_db
    board_io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk), .reset(reset), .sw_in(sw_in[i]),
      .sw_db(sw_db[i]), .sw_rise(sw_rise[i]), .sw_fall(sw_fall[i])
    );
  end
  state_t state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LED_W-1:0] led_out_q, led_out_d;
  logic soc_reset_n_q, soc_reset_n_d, rst_lvl, pwm_on;
`ifdef BOARD_IO_HEARTBEAT_EN
  localparam int HW = cnt_w(HB_CYCLES);
  localparam logic [HW-1:0] HB_MAX = HW'(HB_CYCLES - 1);
  logic [HW-1:0] hb_cnt_q, hb_cnt_d;
  logic hb_q, hb_d;
`endif
  always_comb begin
    rst_lvl       = sw_db[RST_SW];
    // a released reset switch drops back to HOLD from every state
    state_d       = (state_q == ST_HOLD) ? (rst_lvl ? ST_STRETCH : ST_HOLD) :
                    !rst_lvl ? ST_HOLD :
                    (state_q == ST_STRETCH && rcnt_q == POR_MAX) ? ST_RUN : state_q;
    rcnt_d        = (state_q == ST_STRETCH && rst_lvl && rcnt_q != POR_MAX) ? rcnt_q + 1'b1 : '0;
    soc_reset_n_d = (state_d == ST_RUN);
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
    pwm_on        = (&led_duty) | (pwm_cnt_q < led_duty);
    // gated on the next state so LEDs go dark on the same edge soc_reset_n falls
    led_out_d     = (state_d == ST_RUN) ? (led_val & {LED_W{pwm_on}}) : '0;
`ifdef BOARD_IO_HEARTBEAT_EN
    hb_cnt_d      = (state_q != ST_RUN || hb_cnt_q == HB_MAX) ? '0 : hb_cnt_q + 1'b1;
    hb_d          = (state_q != ST_RUN) ? 1'b0 : (hb_cnt_q == HB_MAX) ? ~hb_q : hb_q;
    led_out_d[LED_W-1] = (state_d == ST_RUN) ? hb_d : 1'b1;
`endif
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_HOLD;
      rcnt_q        <= '0;
      soc_reset_n_q <= 1'b0;
      pwm_cnt_q     <= '0;
      led_out_q     <= '0;
`ifdef BOARD_IO_HEARTBEAT_EN
      hb_cnt_q      <= '0;
      hb_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      soc_reset_n_q <= soc_reset_n_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led_out_q     <= led_out_d;
`ifdef BOARD_IO_HEARTBEAT_EN
      hb_cnt_q      <= hb_cnt_d;
      hb_q          <= hb_d;
`endif
    end
  end
  assign soc_reset_n = soc_reset_n_q;
  assign led_out     = led_out_q;
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed self-checking bench for board_io_ctrl (small debounce/POR/PWM counts)
module tb_board_io_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_in, sw_db, sw_rise, sw_fall;
  logic       soc_reset_n;
  logic [7:0] led_val, led_out;
  logic [3:0] led_duty;
`ifdef BOARD_IO_HEARTBEAT_EN
  localparam logic [7:0] LED_MASK = 8'h7F;
`else
  localparam logic [7:0] LED_MASK = 8'hFF;
`endif
  int n_checks = 0, n_errors = 0;
  int r0, f0, r1, f1, db1, up0, dn0, soc_up, soc_dn, bad_led, acc, hits, odd;
  board_io_ctrl #(
    .SW_W(4), .LED_W(8), .DB_CYCLES(4), .POR_CYCLES(8), .RST_SW(0), .PWM_BITS(4)
`ifdef BOARD_IO_HEARTBEAT_EN
    , .HB_CYCLES(3)
`endif
  ) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .sw_db(sw_db), .sw_rise(sw_rise),
    .sw_fall(sw_fall), .soc_reset_n(soc_reset_n), .led_val(led_val),
    .led_duty(led_duty), .led_out(led_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // c counts rising edges since the call; samples on the falling edge
  task automatic watch(input int n);
    logic soc_p;
    r0 = 0; f0 = 0; r1 = 0; f1 = 0; db1 = 0; up0 = 0; dn0 = 0;
    soc_up = 0; soc_dn = 0; bad_led = 0;
    soc_p = soc_reset_n;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (sw_rise[0]) begin r0++; if (up0 == 0) up0 = c; end
      if (sw_fall[0]) begin f0++; if (dn0 == 0) dn0 = c; end
      if (sw_rise[1]) r1++;
      if (sw_fall[1]) f1++;
      if (sw_db[1]) db1++;
      if (soc_reset_n && !soc_p && soc_up == 0) soc_up = c;
      if (!soc_reset_n && soc_p && soc_dn == 0) soc_dn = c;
      if (!soc_reset_n && (led_out & LED_MASK) != 0) bad_led++;
      soc_p = soc_reset_n;
    end
  endtask
  task automatic pwm_count(input logic [3:0] duty, input logic [7:0] val, input int n);
    led_duty = duty;
    led_val = val;
    repeat (2) @(negedge clk);
    hits = 0; odd = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if ((led_out & LED_MASK) == (val & LED_MASK)) hits++;
      else if ((led_out & LED_MASK) != 0) odd++;
    end
  endtask
  initial begin
    reset = 1'b0; sw_in = 4'b0001; led_val = 8'hFF; led_duty = 4'hF;
    repeat (5) @(negedge clk);
    check("rst_db", sw_db, 0);
    check("rst_edges", {sw_rise, sw_fall}, 0);
    check("rst_soc", soc_reset_n, 0);
    check("rst_led", led_out, 0);
    // 1: power-up sequence
    reset = 1'b1;
    watch(25);
    check("pu_db_cycle", up0, 6);
    check("pu_rise_cnt", r0, 1);
    check("pu_por_delay", (soc_up - up0 >= 8) && (soc_up - up0 <= 9), 1);
    check("pu_led_dark", bad_led, 0);
    check("pu_led_run", led_out & LED_MASK, LED_MASK);
    // 2: glitch shorter than the window is dropped, a full-window pulse passes
    sw_in = 4'b0011; watch(3); acc = r1 + db1;
    sw_in = 4'b0001; watch(12); acc += r1 + db1;
    check("glitch3", acc, 0);
    sw_in = 4'b0011; watch(4); acc = r1;
    sw_in = 4'b0001; watch(14); acc += r1;
    check("pulse4_rise", acc, 1);
    check("pulse4_fall", f1, 1);
    check("pulse_soc", soc_reset_n, 1);
    // 3: reset switch released, then restored
    sw_in = 4'b0000; watch(10);
    check("sw0_fall_cnt", f0, 1);
    check("sw0_fall_cycle", dn0, 6);
    check("soc_dn_cycle", soc_dn, 7);
    check("hold_led_dark", bad_led, 0);
    sw_in = 4'b0001; watch(25);
    check("restore_db", up0, 6);
    check("restore_por", (soc_up - up0 >= 8) && (soc_up - up0 <= 9), 1);
    check("restore_soc", soc_reset_n, 1);
    // 4: PWM brightness
    pwm_count(4'd4, 8'hFF, 32);
    check("pwm4_hits", hits, 8);
    check("pwm4_odd", odd, 0);
    pwm_count(4'd1, 8'hFF, 32);
    check("pwm1_hits", hits, 2);
    pwm_count(4'd0, 8'hFF, 16);
    check("pwm0_zero", hits + odd, 0);
    pwm_count(4'hF, 8'hA5, 16);
    check("pwm15_full", hits, 16);
    check("pwm15_odd", odd, 0);
    // 5: block reset in the middle of the stretch
    sw_in = 4'b0000; watch(10);
    sw_in = 4'b0001; watch(12);
    check("mid_db", up0, 6);
    check("mid_no_run", soc_up, 0);
    reset = 1'b0; watch(3);
    check("mid_rst_soc", soc_reset_n, 0);
    check("mid_rst_db", sw_db, 0);
    check("mid_rst_led", led_out, 0);
    reset = 1'b1; watch(25);
    check("rerun_db", up0, 6);
    check("rerun_por", (soc_up - up0 >= 8) && (soc_up - up0 <= 9), 1);
`ifdef BOARD_IO_HEARTBEAT_EN
    // 6: heartbeat LED
    led_val = 8'h00; led_duty = 4'hF;
    sw_in = 4'b0000; watch(10);
    check("hb_hold", led_out, 8'h80);
    sw_in = 4'b0001;
    acc = 0;
    for (int c = 0; c < 40 && !soc_reset_n; c++) @(negedge clk);
    check("hb_run_reached", soc_reset_n, 1);
    for (int c = 0; c < 12; c++) begin
      acc |= int'(led_out[7]) << c;
      if (led_out[6:0] != 0) acc |= 1 << 20;
      @(negedge clk);
    end
    check("hb_pattern", acc, 32'hE38);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
